// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file and its scoreboard.
// Holds default geometry and the pending-vector next-state rule.
// The rule is width-agnostic: callers zero-extend into the widest supported vector.
package gpr_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Widest register file the shared pending rule can describe (256 entries).
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_DEPTH  = 1 << MAX_ADDR_W;

  typedef logic [MAX_DEPTH-1:0]  pend_vec_t;
  typedef logic [MAX_ADDR_W-1:0] pend_addr_t;

  // Next pending vector: a write retires the producer, a reserve installs a new one.
  // The reserve is applied last so a same-cycle reserve+write leaves the bit set.
  function automatic pend_vec_t pend_next(
    input pend_vec_t  pend,
    input logic       wr_en,
    input pend_addr_t wr_a,
    input logic       rsv_en,
    input pend_addr_t rsv_a
  );
    pend_vec_t nxt;
    nxt = pend;
    if (wr_en) begin
      nxt[wr_a] = 1'b0;
    end
    if (rsv_en) begin
      nxt[rsv_a] = 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits plus a running count of outstanding producers.
// Latency: pending vector and count update on the clock edge after a strobe.
// Backpressure: none; reserve and write strobes are accepted every cycle.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [(1<<ADDR_W)-1:0] pend,
  output logic [ADDR_W:0]        pending_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_nxt;

  // Evaluate the shared rule on a widened copy and keep only the live entries.
  always_comb begin
    pend_nxt = DEPTH'(pend_next(pend_vec_t'(pend), wr_en, pend_addr_t'(wr_addr),
                                rsv_en, pend_addr_t'(rsv_addr)));
  end

  // Pending bits and their popcount; the count is derived from the next vector so it
  // can never drift from the bits and moves by at most one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      pending_cnt <= '0;
    end else begin
      pend        <= pend_nxt;
      pending_cnt <= (ADDR_W+1)'($countones(pend_nxt));
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Register file, one write and two read ports, with write bypass and a pending scoreboard.
// Latency: reads combinational (REG_READ=0) or one registered cycle (REG_READ=1).
// Backpressure: none; hazards are reported through the pending outputs for the caller to stall on.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] reg_read_addr_1,
  input  logic [ADDR_W-1:0] reg_read_addr_2,
  output logic [DATA_W-1:0] reg_read_data_1,
  output logic [DATA_W-1:0] reg_read_data_2,
  output logic              reg_pend_1,
  output logic              reg_pend_2,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok;
  logic              rsv_ok;

  logic [ADDR_W-1:0] rd_addr   [2];
  logic [DATA_W-1:0] rd_dat_c  [2];
  logic              rd_pend_c [2];

  assign rd_addr[0] = reg_read_addr_1;
  assign rd_addr[1] = reg_read_addr_2;

  // Strobes aimed at a hardwired zero register are dropped here, so neither the array,
  // the scoreboard nor the bypass ever sees them.
  always_comb begin
    wr_ok  = reg_write_en && !((ZERO_REG != 0) && (reg_write_dest == '0));
    rsv_ok = rsv_en       && !((ZERO_REG != 0) && (rsv_addr == '0));
  end

  // Data array; a write lands at the edge ending the cycle it was presented in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[reg_write_dest] <= reg_write_data;
    end
  end

  gpr_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_ok),
    .wr_addr    (reg_write_dest),
    .rsv_en     (rsv_ok),
    .rsv_addr   (rsv_addr),
    .pend       (pend),
    .pending_cnt(pending_cnt)
  );

  // Per-port read: array value, overridden by an in-flight write, then zero-register masking.
  // A bypassed read is only pending if the same address is being re-reserved right now.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_dat_c[p]  = mem[rd_addr[p]];
      rd_pend_c[p] = pend[rd_addr[p]];
      if (wr_ok && (rd_addr[p] == reg_write_dest)) begin
        rd_dat_c[p]  = reg_write_data;
        rd_pend_c[p] = rsv_ok && (rsv_addr == reg_write_dest);
      end
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_dat_c[p]  = '0;
        rd_pend_c[p] = 1'b0;
      end
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DATA_W-1:0] dat1_q;
      logic [DATA_W-1:0] dat2_q;
      logic              pend1_q;
      logic              pend2_q;

      // Capture the post-bypass read of this cycle for presentation next cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dat1_q  <= '0;
          dat2_q  <= '0;
          pend1_q <= 1'b0;
          pend2_q <= 1'b0;
        end else begin
          dat1_q  <= rd_dat_c[0];
          dat2_q  <= rd_dat_c[1];
          pend1_q <= rd_pend_c[0];
          pend2_q <= rd_pend_c[1];
        end
      end

      assign reg_read_data_1 = dat1_q;
      assign reg_read_data_2 = dat2_q;
      assign reg_pend_1      = pend1_q;
      assign reg_pend_2      = pend2_q;
    end else begin : g_comb_read
      assign reg_read_data_1 = rd_dat_c[0];
      assign reg_read_data_2 = rd_dat_c[1];
      assign reg_pend_1      = rd_pend_c[0];
      assign reg_pend_2      = rd_pend_c[1];
    end
  endgenerate

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with one write port, two read ports, write-to-read bypass, an optional hardwired-zero register and a per-register pending (scoreboard) bit. It replaces the fixed 16×16 register file in the RISC datapath. Decode reserves destination registers through the scoreboard, and operand fetch uses the pending bits to stall on read-after-write hazards.

## Interface
- DATA_W, 16: register width in bits
- ADDR_W, 4: address width; depth = 2**ADDR_W
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes and is never pending
- REG_READ, 0: 0 = combinational read; 1 = read data and pending registered, one-cycle latency

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_write_en  in  1  write strobe
- reg_write_dest  in  ADDR_W  write address
- reg_write_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe; sets the pending bit of rsv_addr
- rsv_addr  in  ADDR_W  register being reserved
- reg_read_addr_1 / reg_read_addr_2  in  ADDR_W  read addresses
- reg_read_data_1 / reg_read_data_2  out  DATA_W  read data
- reg_pend_1 / reg_pend_2  out  1  pending bit of the addressed register
- pending_cnt  out  ADDR_W+1  number of pending bits currently set

## Operation
- Reset (rst_n low, asynchronous):
  - all registers are 0 and all pending bits are 0
  - pending_cnt is 0
  - read outputs are 0 when REG_READ=1
- Write: on a clk edge with reg_write_en=1, the register at reg_write_dest takes reg_write_data and its pending bit clears.
- Reserve: on a clk edge with rsv_en=1, the pending bit of rsv_addr sets.
- Reserve and write to the same address in one cycle: the pending bit ends set (the new producer wins); the data is still written.
- Reserve of a register that is already pending: no change, and pending_cnt does not double-count.
- Write to a register that is not pending: the data is written, and pending and pending_cnt stay unchanged.
- Bypass, same cycle: when reg_write_en=1 and a read address equals reg_write_dest:
  - read data equals reg_write_data
  - the pending output is 0, unless a reserve to that address happens in the same cycle, in which case it is 1
- Both read ports are independent; both may address the same register.
- ZERO_REG=1: address 0 reads 0 and pending 0; writes and reserves to address 0 have no effect, including through the bypass path.
- pending_cnt: popcount of the pending bits, updated every cycle. Per cycle it changes by -1, 0 or +1 at most, and it never wraps.

## Timing
- REG_READ=0:
  - data and pending are combinational from the address, the array and the bypass
  - a write lands in the array at the edge, and bypass covers the cycle before that edge
- REG_READ=1:
  - outputs register at the edge; the sampled value is the post-bypass value of the cycle in which the address was presented
  - latency is 1 cycle
- pending_cnt is registered and reflects the pending state after the last edge.
- rst_n deassertion: the first edge with rst_n high may write or reserve.

## Structure
- Shared package gpr_pkg holds:
  - the default DATA_W and ADDR_W localparams
  - the function pend_next(pend, wr_en, wr_a, rsv_en, rsv_a), returning the next pending vector, used by both RTL and the bench model
- Natural sub-module: gpr_scoreboard, which holds the pending vector, pending_cnt and pend_next. It has clk and rst_n, the write and reserve strobes and addresses, and it outputs the pending vector.
- Top level holds:
  - the data array
  - the bypass mux
  - the ZERO_REG masking
  - the optional output register stage

## Test plan
- Reset with random traffic, then pull rst_n low mid-cycle (not on an edge) → all outputs and pending_cnt read 0 immediately; after release, reading r5 returns 0.
- Write r3=16'hBEEF, then read r3 on both ports next cycle → 16'hBEEF on both ports, pending 0; with REG_READ=1 the data appears one cycle after the address.
- Read r7 while writing r7=16'h1234 in the same cycle → read port shows 16'h1234 that cycle (REG_READ=0).
- Reserve r2 → reg_pend=1 and pending_cnt=1. Reserve r2 again → pending_cnt stays 1. Reserve and write r2 in the same cycle → still pending, data updated. Write r2 alone → pending 0 and pending_cnt=0.
- ZERO_REG=1: write r0=16'hFFFF and reserve r0 → r0 reads 0, pend 0, pending_cnt unchanged. ZERO_REG=0: r0 reads 16'hFFFF.
- DATA_W=32, ADDR_W=5: reserve all 31 nonzero registers → pending_cnt=31; release them with writes in random order → count decrements by 1 per write and ends at 0, with no wrap.
